// File: rtl/wb_gpio_ctrl_if.sv
// Wishbone classic slave bus bundle for the GPIO controller (32-bit data, byte address).
// Master drives cyc/stb/we/sel/adr/dat_i; slave returns ack and read data.
interface wb_gpio_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_gpio_ctrl.sv
// Wishbone GPIO controller: OUT/OEB/IEN/STAT registers, 2-flop input sync, sticky edge status, irq.
// Latency: ack one cycle after a hit, then one forced-low cycle; irq four edges after a pin change.
// Optional falling-edge polarity register (POL) is built when WB_GPIO_FALL_EDGE_EN is defined.
module wb_gpio_ctrl #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          IO_W     = 38
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,
    wb_gpio_ctrl_if.slave   wbs,
    input  logic [IO_W-1:0] io_in,
    output logic [IO_W-1:0] io_out,
    output logic [IO_W-1:0] io_oeb,
    output logic            irq_o
);
    localparam logic [4:0] IDX_OUT  = 5'd0;
    localparam logic [4:0] IDX_OEB  = 5'd1;
    localparam logic [4:0] IDX_IN   = 5'd2;
    localparam logic [4:0] IDX_IEN  = 5'd3;
    localparam logic [4:0] IDX_STAT = 5'd4;
    localparam logic [4:0] IDX_POL  = 5'd5;

    logic            ack_q;
    logic [31:0]     dat_q;
    logic            irq_q;
    logic [IO_W-1:0] out_q, oeb_q, ien_q, stat_q;
    logic [IO_W-1:0] s1_q, s2_q, prev_q;
    logic [IO_W-1:0] evt, clr, wmask, wdat;
    logic [63:0]     m64, d64, rd64;
    logic [31:0]     mask32, rdata;
    logic [4:0]      idx;
    logic            hit, acc, wr, hi;
    logic            unused_adr;

    // Each register is a 64-bit view split into LO/HI words; adr[2] picks the word.
    assign hit = wbs.wbs_cyc_i & wbs.wbs_stb_i & (wbs.wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign acc = hit & ~ack_q;
    assign wr  = acc & wbs.wbs_we_i;
    assign idx = wbs.wbs_adr_i[7:3];
    assign hi  = wbs.wbs_adr_i[2];
    assign unused_adr = ^wbs.wbs_adr_i[1:0];

    assign mask32 = {{8{wbs.wbs_sel_i[3]}}, {8{wbs.wbs_sel_i[2]}},
                     {8{wbs.wbs_sel_i[1]}}, {8{wbs.wbs_sel_i[0]}}};
    assign m64    = hi ? {mask32, 32'h0} : {32'h0, mask32};
    assign d64    = hi ? {wbs.wbs_dat_i, 32'h0} : {32'h0, wbs.wbs_dat_i};
    assign wmask  = IO_W'(m64);
    assign wdat   = IO_W'(d64);
    assign clr    = (wr && idx == IDX_STAT) ? (wdat & wmask) : '0;

`ifdef WB_GPIO_FALL_EDGE_EN
    logic [IO_W-1:0] pol_q;
    // XOR with POL turns a falling edge into a rising one for the detector.
    assign evt = (s2_q ^ pol_q) & ~(prev_q ^ pol_q);
`else
    assign evt = s2_q & ~prev_q;
`endif

    always_comb begin
        rd64 = 64'h0;
        case (idx)
            IDX_OUT:  rd64 = 64'(out_q);
            IDX_OEB:  rd64 = 64'(oeb_q);
            IDX_IN:   rd64 = 64'(s2_q);
            IDX_IEN:  rd64 = 64'(ien_q);
            IDX_STAT: rd64 = 64'(stat_q);
`ifdef WB_GPIO_FALL_EDGE_EN
            IDX_POL:  rd64 = 64'(pol_q);
`endif
            default:  rd64 = 64'h0;
        endcase
        rdata = hi ? rd64[63:32] : rd64[31:0];
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ack_q  <= 1'b0;
            dat_q  <= '0;
            irq_q  <= 1'b0;
            out_q  <= '0;
            oeb_q  <= '1;
            ien_q  <= '0;
            stat_q <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
`ifdef WB_GPIO_FALL_EDGE_EN
            pol_q  <= '0;
`endif
        end else begin
            ack_q  <= acc;
            dat_q  <= (acc && !wbs.wbs_we_i) ? rdata : 32'h0;
            s1_q   <= io_in;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            // A new edge wins over a same-cycle W1C of that bit.
            stat_q <= (stat_q & ~clr) | evt;
            irq_q  <= |(stat_q & ien_q);
            if (wr) begin
                case (idx)
                    IDX_OUT: out_q <= (out_q & ~wmask) | (wdat & wmask);
                    IDX_OEB: oeb_q <= (oeb_q & ~wmask) | (wdat & wmask);
                    IDX_IEN: ien_q <= (ien_q & ~wmask) | (wdat & wmask);
`ifdef WB_GPIO_FALL_EDGE_EN
                    IDX_POL: pol_q <= (pol_q & ~wmask) | (wdat & wmask);
`endif
                    default: ;
                endcase
            end
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign io_out        = out_q;
    assign io_oeb        = oeb_q;
    assign irq_o         = irq_q;
endmodule

// File: tb/tb_wb_gpio_ctrl.sv
// Bench for wb_gpio_ctrl: register table with read scoreboard, plus handshake, irq and corner sequences.
module tb_wb_gpio_ctrl;
    localparam int          IO_W = 38;
    localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef WB_GPIO_FALL_EDGE_EN
    localparam logic [31:0] POL_LO_EXP = 32'hFFFF_FFFF;
    localparam logic [31:0] POL_HI_EXP = 32'h0000_003F;
`else
    localparam logic [31:0] POL_LO_EXP = 32'h0;
    localparam logic [31:0] POL_HI_EXP = 32'h0;
`endif

    typedef struct {
        logic        we;
        logic [7:0]  off;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [IO_W-1:0] io_in = '0;
    logic [IO_W-1:0] io_out, io_oeb;
    logic            irq;
    int              checks = 0;
    int              errors = 0;
    logic [31:0]     exp_q[$];
    vec_t            vt[$];

    wb_gpio_ctrl_if bus();

    wb_gpio_ctrl #(.BASE_ADR(BASE), .IO_W(IO_W)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbs        (bus),
        .io_in      (io_in),
        .io_out     (io_out),
        .io_oeb     (io_oeb),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic we, input logic [7:0] off, input logic [31:0] dat,
                                input logic [3:0] sel, input logic [31:0] exp);
        vec_t v;
        v.we = we; v.off = off; v.dat = dat; v.sel = sel; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'h0;
        bus.wbs_dat_i = 32'h0;
    endtask

    task automatic bus_drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = sel;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
    endtask

    // One access; reads push their expectation, popped and compared at ack.
    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input logic [31:0] exp, output int lat);
        int n;
        logic [31:0] e;
        @(negedge clk);
        bus_drive(we, adr, dat, sel);
        if (!we) exp_q.push_back(exp);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.wbs_ack_o && n < 10);
        lat = n;
        if (!bus.wbs_ack_o) begin
            chk($sformatf("ack_timeout %h", adr), 64'(n), 64'd1);
            if (!we) void'(exp_q.pop_front());
        end else if (!we) begin
            e = exp_q.pop_front();
            chk($sformatf("rd %h", adr), 64'(bus.wbs_dat_o), 64'(e));
        end
        bus_idle();
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] dat);
        int lat;
        wb_access(1'b1, BASE + 32'(off), dat, 4'hF, 32'h0, lat);
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp);
        int lat;
        wb_access(1'b0, BASE + 32'(off), 32'h0, 4'hF, exp, lat);
    endtask

    initial begin
        int lat;
        int acks;
        logic [5:0] pat;

        vt.push_back(mk(1'b0, 8'h08, 32'h0,         4'hF, 32'hFFFF_FFFF));
        vt.push_back(mk(1'b0, 8'h0C, 32'h0,         4'hF, 32'h0000_003F));
        vt.push_back(mk(1'b1, 8'h00, 32'hA5A5_A5A5, 4'h3, 32'h0));
        vt.push_back(mk(1'b0, 8'h00, 32'h0,         4'hF, 32'h0000_A5A5));
        vt.push_back(mk(1'b1, 8'h04, 32'hFFFF_FFFF, 4'hF, 32'h0));
        vt.push_back(mk(1'b0, 8'h04, 32'h0,         4'hF, 32'h0000_003F));
        vt.push_back(mk(1'b1, 8'h08, 32'h0,         4'h1, 32'h0));
        vt.push_back(mk(1'b0, 8'h08, 32'h0,         4'hF, 32'hFFFF_FF00));
        vt.push_back(mk(1'b0, 8'h10, 32'h0,         4'hF, 32'hDEAD_BEEF));
        vt.push_back(mk(1'b0, 8'h14, 32'h0,         4'hF, 32'h0000_0015));
        vt.push_back(mk(1'b0, 8'h20, 32'h0,         4'hF, 32'hDEAD_BEEF));
        vt.push_back(mk(1'b0, 8'h24, 32'h0,         4'hF, 32'h0000_0015));
        vt.push_back(mk(1'b1, 8'h20, 32'hFFFF_FFFF, 4'hF, 32'h0));
        vt.push_back(mk(1'b1, 8'h24, 32'hFFFF_FFFF, 4'hF, 32'h0));
        vt.push_back(mk(1'b0, 8'h20, 32'h0,         4'hF, 32'h0));
        vt.push_back(mk(1'b0, 8'h24, 32'h0,         4'hF, 32'h0));
        vt.push_back(mk(1'b0, 8'h30, 32'h0,         4'hF, 32'h0));
        vt.push_back(mk(1'b1, 8'h30, 32'hFFFF_FFFF, 4'hF, 32'h0));
        vt.push_back(mk(1'b0, 8'h30, 32'h0,         4'hF, 32'h0));
        vt.push_back(mk(1'b1, 8'h00, 32'h0,         4'h0, 32'h0));
        vt.push_back(mk(1'b0, 8'h00, 32'h0,         4'hF, 32'h0000_A5A5));
        vt.push_back(mk(1'b1, 8'h28, 32'hFFFF_FFFF, 4'hF, 32'h0));
        vt.push_back(mk(1'b0, 8'h28, 32'h0,         4'hF, POL_LO_EXP));
        vt.push_back(mk(1'b1, 8'h2C, 32'hFFFF_FFFF, 4'hF, 32'h0));
        vt.push_back(mk(1'b0, 8'h2C, 32'h0,         4'hF, POL_HI_EXP));
        vt.push_back(mk(1'b1, 8'h28, 32'h0,         4'hF, 32'h0));
        vt.push_back(mk(1'b1, 8'h2C, 32'h0,         4'hF, 32'h0));

        bus_idle();
        repeat (3) @(negedge clk);
        chk("rst_io_out", 64'(io_out), 64'h0);
        chk("rst_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
        chk("rst_ack", 64'(bus.wbs_ack_o), 64'h0);
        chk("rst_dat", 64'(bus.wbs_dat_o), 64'h0);
        chk("rst_irq", 64'(irq), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);

        io_in = 38'h15_DEAD_BEEF;
        repeat (4) @(negedge clk);

        foreach (vt[i]) begin
            wb_access(vt[i].we, BASE + 32'(vt[i].off), vt[i].dat, vt[i].sel, vt[i].exp, lat);
            chk($sformatf("ack_lat v%0d", i), 64'(lat), 64'd1);
            @(negedge clk);
            chk($sformatf("ack_one_cycle v%0d", i), 64'(bus.wbs_ack_o), 64'h0);
        end

        io_in = '0;
        repeat (4) @(negedge clk);
        chk("io_out_after_table", 64'(io_out), 64'h3F_0000_A5A5);
        chk("io_oeb_after_table", 64'(io_oeb), 64'h3F_FFFF_FF00);
        chk("irq_ien_zero", 64'(irq), 64'h0);

        // Held strobe: acks on alternate cycles, data only in ack cycles.
        @(negedge clk);
        bus_drive(1'b0, BASE + 32'h10, 32'h0, 4'hF);
        #1;
        pat = '0;
        pat[0] = bus.wbs_ack_o;
        for (int c = 1; c < 6; c++) begin
            @(negedge clk);
            pat[c] = bus.wbs_ack_o;
            if (c == 2) chk("dat_zero_no_ack", 64'(bus.wbs_dat_o), 64'h0);
        end
        bus_idle();
        chk("held_stb_ack_pattern", 64'(pat), 64'(6'b101010));

        // Out-of-window address is never acked.
        @(negedge clk);
        bus_drive(1'b0, BASE + 32'h100, 32'h0, 4'hF);
        acks = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.wbs_ack_o) acks++;
        end
        bus_idle();
        chk("out_of_window_acks", 64'(acks), 64'h0);

        // Pin rise to irq latency, then W1C clears irq one cycle after ack.
        wr(8'h18, 32'h1);
        @(negedge clk);
        io_in[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("irq_low_edge3", 64'(irq), 64'h0);
        @(posedge clk);
        #1 chk("irq_high_edge4", 64'(irq), 64'h1);
        rd(8'h20, 32'h1);
        wr(8'h20, 32'h1);
        chk("irq_in_w1c_ack", 64'(irq), 64'h1);
        @(negedge clk);
        chk("irq_after_w1c", 64'(irq), 64'h0);

        // Clearing IEN drops irq while STAT is retained.
        io_in[0] = 1'b0;
        repeat (4) @(negedge clk);
        io_in[0] = 1'b1;
        repeat (5) @(negedge clk);
        chk("irq_rearm", 64'(irq), 64'h1);
        wr(8'h18, 32'h0);
        chk("irq_in_ien_ack", 64'(irq), 64'h1);
        @(negedge clk);
        chk("irq_after_ien0", 64'(irq), 64'h0);
        rd(8'h20, 32'h1);
        wr(8'h20, 32'h1);

        // W1C of bit 5 lands on the same edge the rise sets it: set wins.
        @(negedge clk);
        io_in[5] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus_drive(1'b1, BASE + 32'h20, 32'h20, 4'hF);
        @(negedge clk);
        chk("collision_ack", 64'(bus.wbs_ack_o), 64'h1);
        bus_idle();
        rd(8'h20, 32'h20);

`ifdef WB_GPIO_FALL_EDGE_EN
        wr(8'h2C, 32'h1);
        io_in[32] = 1'b1;
        repeat (5) @(negedge clk);
        wr(8'h24, 32'hFFFF_FFFF);
        rd(8'h24, 32'h0);
        io_in[32] = 1'b0;
        repeat (5) @(negedge clk);
        rd(8'h24, 32'h1);
`else
        wr(8'h28, 32'hFFFF_FFFF);
        rd(8'h28, 32'h0);
`endif

        // Reset during an acked write, and a write held across reset.
        @(negedge clk);
        bus_drive(1'b1, BASE + 32'h00, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        chk("mid_ack_before_rst", 64'(bus.wbs_ack_o), 64'h1);
        #1 rst_n = 1'b0;
        #1 chk("mid_rst_ack_drop", 64'(bus.wbs_ack_o), 64'h0);
        chk("mid_rst_io_out", 64'(io_out), 64'h0);
        @(negedge clk);
        chk("rst_held_no_write", 64'(io_out), 64'h0);
        chk("rst_held_no_ack", 64'(bus.wbs_ack_o), 64'h0);
        bus_idle();
        @(negedge clk);
        rst_n = 1'b1;
        rd(8'h08, 32'hFFFF_FFFF);
        rd(8'h00, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_gpio_ctrl.md
Name: wb_gpio_ctrl

Overview:
- Wishbone classic slave inside user_proj_example, directly downstream of the wrapper's wbs_* and io_* pins.
- Drives io_out/io_oeb from CPU-writable registers and samples io_in through a 2-flop synchroniser.
- Latches per-pin rising edges into sticky status bits and raises user_irq[0] when any enabled status bit is set.

Parameters:
- BASE_ADR, 32'h3000_0000, Wishbone base address; window is BASE_ADR..BASE_ADR+0xFF.
- IO_W, 38, number of GPIO pins (legal range 33..64).

Ports:
- wb_clk_i  in  1  clock; all state on rising edge.
- wb_rst_n_i  in  1  reset, asynchronous assert, active-low.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte lane select.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- io_in  in  IO_W  pad inputs, asynchronous to wb_clk_i.
- io_out  out  IO_W  pad output values.
- io_oeb  out  IO_W  pad output enable, active-low.
- irq_o  out  1  interrupt, wired to user_irq[0].

Behaviour:
- Reset is asynchronous, active-low. Values while and after reset:
  - io_out = 0, io_oeb = all 1s, wbs_ack_o = 0, wbs_dat_o = 0, irq_o = 0.
  - All registers and synchroniser flops cleared.
- Register map (offset from BASE_ADR). LO holds bits [31:0]; HI holds bits [IO_W-1:32] in its low bits; unused HI bits read 0.
  - 0x00/0x04 OUT, RW.
  - 0x08/0x0C OEB, RW, reset all 1s.
  - 0x10/0x14 IN, RO, synchronised value.
  - 0x18/0x1C IEN, RW.
  - 0x20/0x24 STAT, W1C.
  - Other offsets in the window read 0; writes to them are ignored.
- Decode: hit = cyc & stb & (wbs_adr_i[31:8] == BASE_ADR[31:8]). Addresses outside the window are never acked.
- Handshake:
  - Hit in cycle N with ack low → wbs_ack_o high in cycle N+1 for exactly one cycle.
  - Ack is then forced low for one cycle even if stb stays high, so back-to-back accesses ack every second cycle.
  - Writes take effect at the same edge that raises ack.
- Writes: per-byte enables from wbs_sel_i; sel = 0 still acks but changes nothing.
  - STAT: each 1 written in an enabled byte clears that bit.
- Reads: wbs_dat_o carries register data only in the ack cycle, 0 otherwise.
- Synchroniser: io_in → s1 → s2; IN reads s2.
- Edge detect and interrupt:
  - prev <= s2; rise = s2 & ~prev.
  - STAT[i] set by rise[i] regardless of IEN.
  - Pin change before edge 1 → s2 at edge 2 → STAT set at edge 3 → irq_o (registered |(STAT & IEN)) at edge 4.
- Simultaneous events:
  - Rise and W1C on the same STAT bit in the same cycle → bit stays set (set wins).
  - IEN written to 0 → irq_o drops the next cycle; STAT is retained.
- Reset mid-transaction: ack is dropped immediately and no write is applied. The master must re-issue the access.

Optional Feature:
- Macro: WB_GPIO_FALL_EDGE_EN.
- Defined:
  - Adds POL register at 0x28/0x2C, RW, reset 0.
  - POL[i] = 1 → STAT[i] is set on the falling edge (~s2 & prev) instead of the rising edge. Latency is unchanged.
- Undefined:
  - 0x28/0x2C read 0 and writes are ignored.
  - Rising-edge detection only; no POL flops are instantiated.

Test Plan:
- Reset → io_oeb = all 1s, io_out = 0, irq_o = 0. Read 0x08 → 32'hFFFF_FFFF; read 0x0C → 32'h0000_003F.
- Write 0x00 = 32'hA5A5_A5A5 with sel = 4'b0011 → io_out[31:0] = 32'h0000_A5A5. Ack is one cycle, the cycle after stb.
- Hold stb for 6 cycles on a read of 0x10 → ack pulses in cycles 2, 4 and 6 only. Address 32'h3000_0100 → no ack within 10 cycles.
- IEN_LO = 1; drive io_in[0] 0→1 → STAT_LO = 1 at edge 3, irq_o = 1 at edge 4. W1C 0x20 = 1 → irq_o = 0 one cycle after ack.
- Issue W1C to STAT bit 5 in the same cycle a new rise reaches bit 5 → STAT_LO[5] remains 1.
- With WB_GPIO_FALL_EDGE_EN: POL_HI = 1; io_in[32] 1→0 → STAT_HI[0] = 1. Without the macro: read 0x28 → 0 after writing 32'hFFFF_FFFF.
